// File: rtl/game_pkg.sv
// Shared constants and types for the BCD score counter.
package game_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int SCORE_W    = DIGIT_W * NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_e;

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit of add/subtract with decimal carry/borrow; chained to form a multi-digit unit.
module bcd_digit_addsub
  import game_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               cin_i,
  input  logic               sub_i,
  output logic [DIGIT_W-1:0] s_o,
  output logic               cout_o
);

  logic [DIGIT_W:0] raw;
  logic [DIGIT_W:0] adj;

  // Binary add/sub, then decimal correction: +6 past 9 on add, +10 (mod 16) on underflow for sub.
  always_comb begin
    raw    = '0;
    adj    = '0;
    s_o    = '0;
    cout_o = 1'b0;
    if (!sub_i) begin
      raw = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT_W{1'b0}}, cin_i};
      adj = raw + (DIGIT_W+1)'(6);
      if (raw > (DIGIT_W+1)'(9)) begin
        s_o    = adj[DIGIT_W-1:0];
        cout_o = 1'b1;
      end else begin
        s_o    = raw[DIGIT_W-1:0];
      end
    end else begin
      raw = {1'b0, a_i} - {1'b0, b_i} - {{DIGIT_W{1'b0}}, cin_i};
      adj = raw + (DIGIT_W+1)'(10);
      if (raw[DIGIT_W]) begin
        s_o    = adj[DIGIT_W-1:0];
        cout_o = 1'b1;
      end else begin
        s_o    = raw[DIGIT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bcd_score_counter.sv
// Game score counter: packed-BCD score with saturating add, floored penalty and session best.
module bcd_score_counter
  import game_pkg::*;
#(
  parameter logic [SCORE_W-1:0] MAX_BCD    = 16'h9999,
  parameter bit                 PENALTY_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  input  logic [DIGIT_W-1:0] pts,
  input  logic               miss,
  input  logic               over,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best,
  output logic [1:0]         state,
  output logic               new_best
);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               new_best_q, new_best_d;

  // Single shared arithmetic chain: hit adds pts, otherwise subtract 1 (the penalty).
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] opnd;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] res;
  logic [NUM_DIGITS:0]                cy;
  logic                               sub;
  logic [SCORE_W-1:0]                 add_sat;
  logic [SCORE_W-1:0]                 sub_flr;

  assign sub   = ~hit;
  assign cy[0] = 1'b0;

  // Operand is a single low digit; upper digits only propagate carry/borrow.
  always_comb begin
    opnd    = '0;
    opnd[0] = hit ? pts : DIGIT_W'(1);
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit_addsub u_dig (
      .a_i   (score_q[g*DIGIT_W +: DIGIT_W]),
      .b_i   (opnd[g]),
      .cin_i (cy[g]),
      .sub_i (sub),
      .s_o   (res[g]),
      .cout_o(cy[g+1])
    );
  end

  // Clamp: carry out of the top digit or exceeding the ceiling saturates; borrow out floors at zero.
  always_comb begin
    add_sat = (cy[NUM_DIGITS] || (res > MAX_BCD)) ? MAX_BCD : res;
    sub_flr = cy[NUM_DIGITS] ? '0 : res;
  end

  // Next-state logic: over beats start beats hit beats miss in RUN.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    best_d     = best_q;
    new_best_d = new_best_q;
    case (state_q)
      ST_IDLE: begin
        score_d = '0;
        if (start && !over) begin
          state_d    = ST_RUN;
          new_best_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (over) begin
          state_d = ST_OVER;
          if (score_q > best_q) begin
            best_d     = score_q;
            new_best_d = 1'b1;
          end else begin
            new_best_d = 1'b0;
          end
        end else if (start) begin
          score_d = '0;
        end else if (hit) begin
          if (pts <= DIGIT_W'(9)) score_d = add_sat;
        end else if (miss && PENALTY_EN) begin
          score_d = sub_flr;
        end
      end
      ST_OVER: begin
        if (start && !over) begin
          state_d    = ST_RUN;
          score_d    = '0;
          new_best_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        score_d    = '0;
        new_best_d = 1'b0;
      end
    endcase
  end

  // State registers; reset clears the session best as well.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      best_q     <= '0;
      new_best_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      best_q     <= best_d;
      new_best_q <= new_best_d;
    end
  end

  assign score    = score_q;
  assign best     = best_q;
  assign state    = state_q;
  assign new_best = new_best_q;

endmodule
